// File: rtl/footies_pkg.sv
// Shared types for the footies player logic: action states and frame-counter width.
package footies_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WALK_F      = 3'd1,
        WALK_B      = 3'd2,
        ATK_STARTUP = 3'd3,
        ATK_ACTIVE  = 3'd4,
        ATK_RECOVER = 3'd5,
        HITSTUN     = 3'd6
    } action_e;

    localparam int FCNT_W = 5;

    // States that run on the frame counter and ignore walk/attack input.
    function automatic logic is_busy(action_e s);
        return (s == ATK_STARTUP) || (s == ATK_ACTIVE) ||
               (s == ATK_RECOVER) || (s == HITSTUN);
    endfunction

endpackage

// File: rtl/fighter_action_ctrl_btn_sync.sv
// Two-flop synchroniser for the asynchronous button levels.
module btn_sync #(
    parameter int W = 3
) (
    input  logic         clk_pix,
    input  logic         sim_rst,
    input  logic [W-1:0] raw,
    output logic [W-1:0] synced
);

    logic [W-1:0] meta;

    always_ff @(posedge clk_pix or posedge sim_rst) begin
        if (sim_rst) begin
            meta   <= '0;
            synced <= '0;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/fighter_action_ctrl.sv
// Per-player action sequencer: frame-stepped action FSM, phase counter and X position.
//
// state       | meaning
// IDLE        | standing, no movement
// WALK_F      | walking forward at FWD_SPD per frame
// WALK_B      | walking back at BACK_SPD per frame
// ATK_STARTUP | attack wind-up, STARTUP frames
// ATK_ACTIVE  | hitbox live, ACTIVE frames
// ATK_RECOVER | attack cooldown, RECOVERY frames
// HITSTUN     | reeling from a hit, pushed back PUSHBACK per frame
module fighter_action_ctrl
    import footies_pkg::*;
#(
    parameter int X_INIT     = 100,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 639,
    parameter int FACE_RIGHT = 1,
    parameter int FWD_SPD    = 2,
    parameter int BACK_SPD   = 1,
    parameter int STARTUP    = 5,
    parameter int ACTIVE     = 3,
    parameter int RECOVERY   = 8,
    parameter int HITSTUN_N  = 12,
    parameter int PUSHBACK   = 2
) (
    input  logic       clk_pix,
    input  logic       sim_rst,
    input  logic       frame_tick,
    input  logic       freeze,
    input  logic       btn_fwd,
    input  logic       btn_back,
    input  logic       btn_atk,
    input  logic       hit_in,
    output logic [9:0] pos_x,
    output logic [2:0] act_state,
    output logic       hitbox_on,
    output logic       busy
);

    localparam int FWD_DI  = (FACE_RIGHT != 0) ? FWD_SPD   : -FWD_SPD;
    localparam int BACK_DI = (FACE_RIGHT != 0) ? -BACK_SPD : BACK_SPD;
    localparam int PUSH_DI = (FACE_RIGHT != 0) ? -PUSHBACK : PUSHBACK;

    localparam logic signed [11:0] FWD_D  = 12'(FWD_DI);
    localparam logic signed [11:0] BACK_D = 12'(BACK_DI);
    localparam logic signed [11:0] PUSH_D = 12'(PUSH_DI);
    localparam logic signed [11:0] XMIN_S = 12'(X_MIN);
    localparam logic signed [11:0] XMAX_S = 12'(X_MAX);

    localparam logic [FCNT_W-1:0] CNT_STARTUP = FCNT_W'(STARTUP - 1);
    localparam logic [FCNT_W-1:0] CNT_ACTIVE  = FCNT_W'(ACTIVE - 1);
    localparam logic [FCNT_W-1:0] CNT_RECOVER = FCNT_W'(RECOVERY - 1);
    localparam logic [FCNT_W-1:0] CNT_HIT     = FCNT_W'(HITSTUN_N - 1);

    action_e             state, nxt_state;
    logic [FCNT_W-1:0]   frame_cnt, nxt_cnt;
    logic [9:0]          nxt_pos;
    logic                hit_pend, atk_prev;
    logic                fwd_s, back_s, atk_s;
    logic                step, press;
    logic signed [11:0]  delta, pos_sum;

    btn_sync #(.W(3)) u_btn_sync (
        .clk_pix (clk_pix),
        .sim_rst (sim_rst),
        .raw     ({btn_fwd, btn_back, btn_atk}),
        .synced  ({fwd_s, back_s, atk_s})
    );

    assign step  = frame_tick & ~freeze;
    assign press = atk_s & ~atk_prev;

    // A hit arriving on the consuming step cycle survives for the next step.
    always_ff @(posedge clk_pix or posedge sim_rst) begin
        if (sim_rst)      hit_pend <= 1'b0;
        else if (freeze)  hit_pend <= 1'b0;
        else if (hit_in)  hit_pend <= 1'b1;
        else if (step)    hit_pend <= 1'b0;
    end

    always_ff @(posedge clk_pix or posedge sim_rst) begin
        if (sim_rst) begin
            state     <= IDLE;
            frame_cnt <= '0;
            pos_x     <= 10'(X_INIT);
            atk_prev  <= 1'b0;
        end else if (step) begin
            state     <= nxt_state;
            frame_cnt <= nxt_cnt;
            pos_x     <= nxt_pos;
            atk_prev  <= atk_s;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_cnt   = frame_cnt;
        if (hit_pend) begin
            nxt_state = HITSTUN;
            nxt_cnt   = CNT_HIT;
        end else if (is_busy(state)) begin
            if (frame_cnt != '0) begin
                nxt_cnt = frame_cnt - FCNT_W'(1);
            end else begin
                case (state)
                    ATK_STARTUP: begin nxt_state = ATK_ACTIVE;  nxt_cnt = CNT_ACTIVE;  end
                    ATK_ACTIVE:  begin nxt_state = ATK_RECOVER; nxt_cnt = CNT_RECOVER; end
                    default:     nxt_state = IDLE;
                endcase
            end
        end else if (press) begin
            nxt_state = ATK_STARTUP;
            nxt_cnt   = CNT_STARTUP;
        end else if (fwd_s ^ back_s) begin
            nxt_state = fwd_s ? WALK_F : WALK_B;
        end else begin
            nxt_state = IDLE;
        end

        // Movement follows the state being entered on this step.
        case (nxt_state)
            WALK_F:  delta = FWD_D;
            WALK_B:  delta = BACK_D;
            HITSTUN: delta = PUSH_D;
            default: delta = '0;
        endcase
        pos_sum = $signed({2'b00, pos_x}) + delta;
        if (pos_sum < XMIN_S)      nxt_pos = 10'(X_MIN);
        else if (pos_sum > XMAX_S) nxt_pos = 10'(X_MAX);
        else                       nxt_pos = pos_sum[9:0];
    end

    assign act_state = state;
    assign hitbox_on = (state == ATK_ACTIVE);
    assign busy      = is_busy(state);

endmodule

// File: tb/tb_fighter_action_ctrl.sv
// Directed bench for fighter_action_ctrl: walking, clamping, attack phases, hitstun, freeze, reset.
module tb_fighter_action_ctrl;
    import footies_pkg::*;

    logic       clk_pix = 1'b0;
    logic       sim_rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic       freeze = 1'b0;
    logic       btn_fwd = 1'b0;
    logic       btn_back = 1'b0;
    logic       btn_atk = 1'b0;
    logic       hit_in = 1'b0;
    logic [9:0] pos_x;
    logic [2:0] act_state;
    logic       hitbox_on;
    logic       busy;

    int passed = 0;
    int total  = 0;
    int exp_pos;

    fighter_action_ctrl dut (
        .clk_pix    (clk_pix),
        .sim_rst    (sim_rst),
        .frame_tick (frame_tick),
        .freeze     (freeze),
        .btn_fwd    (btn_fwd),
        .btn_back   (btn_back),
        .btn_atk    (btn_atk),
        .hit_in     (hit_in),
        .pos_x      (pos_x),
        .act_state  (act_state),
        .hitbox_on  (hitbox_on),
        .busy       (busy)
    );

    always #5 clk_pix = ~clk_pix;

    // Two idle cycles let button changes clear the synchroniser before the tick.
    task automatic do_step();
        repeat (2) @(negedge clk_pix);
        frame_tick = 1'b1;
        @(negedge clk_pix);
        frame_tick = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk_pix);
        sim_rst = 1'b1;
        repeat (2) @(negedge clk_pix);
        sim_rst = 1'b0;
        @(negedge clk_pix);
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (pos_x !== 10'd100) $display("FAIL reset_pos got %0d exp 100", pos_x); else passed++;
        total++; if (act_state !== IDLE) $display("FAIL reset_state got %0d exp %0d", act_state, IDLE); else passed++;
        total++; if (hitbox_on !== 1'b0) $display("FAIL reset_hitbox got %0b exp 0", hitbox_on); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b exp 0", busy); else passed++;
    endtask

    task automatic test_walk();
        btn_fwd = 1'b1;
        exp_pos = 100;
        for (int k = 1; k <= 10; k++) begin
            do_step();
            exp_pos += 2;
            total++; if (act_state !== WALK_F) $display("FAIL walk_state step %0d got %0d exp %0d", k, act_state, WALK_F); else passed++;
            total++; if (pos_x !== 10'(exp_pos)) $display("FAIL walk_pos step %0d got %0d exp %0d", k, pos_x, exp_pos); else passed++;
            total++; if (hitbox_on !== 1'b0) $display("FAIL walk_hitbox step %0d got %0b exp 0", k, hitbox_on); else passed++;
        end
    endtask

    task automatic test_clamp();
        for (int k = 0; k < 259; k++) do_step();
        total++; if (pos_x !== 10'd638) $display("FAIL clamp_pre got %0d exp 638", pos_x); else passed++;
        for (int k = 1; k <= 3; k++) begin
            do_step();
            total++; if (pos_x !== 10'd639) $display("FAIL clamp_max step %0d got %0d exp 639", k, pos_x); else passed++;
        end
        btn_fwd  = 1'b0;
        btn_back = 1'b1;
        for (int k = 0; k < 639; k++) do_step();
        total++; if (pos_x !== 10'd0) $display("FAIL clamp_back_reach got %0d exp 0", pos_x); else passed++;
        for (int k = 1; k <= 3; k++) begin
            do_step();
            total++; if (pos_x !== 10'd0) $display("FAIL clamp_min step %0d got %0d exp 0", k, pos_x); else passed++;
            total++; if (act_state !== WALK_B) $display("FAIL clamp_min_state step %0d got %0d exp %0d", k, act_state, WALK_B); else passed++;
        end
        btn_back = 1'b0;
        do_step();
        total++; if (act_state !== IDLE) $display("FAIL release_idle got %0d exp %0d", act_state, IDLE); else passed++;
    endtask

    task automatic test_attack();
        logic [2:0] exp_st;
        apply_reset();
        btn_atk = 1'b1;
        for (int k = 1; k <= 19; k++) begin
            do_step();
            if (k <= 5)       exp_st = ATK_STARTUP;
            else if (k <= 8)  exp_st = ATK_ACTIVE;
            else if (k <= 16) exp_st = ATK_RECOVER;
            else              exp_st = IDLE;
            total++; if (act_state !== exp_st) $display("FAIL atk_state step %0d got %0d exp %0d", k, act_state, exp_st); else passed++;
            total++; if (busy !== (k <= 16)) $display("FAIL atk_busy step %0d got %0b exp %0b", k, busy, (k <= 16)); else passed++;
            total++; if (hitbox_on !== (k >= 6 && k <= 8)) $display("FAIL atk_hitbox step %0d got %0b exp %0b", k, hitbox_on, (k >= 6 && k <= 8)); else passed++;
            total++; if (pos_x !== 10'd100) $display("FAIL atk_pos step %0d got %0d exp 100", k, pos_x); else passed++;
        end
        btn_atk = 1'b0;
        do_step();
    endtask

    task automatic test_hitstun();
        btn_atk = 1'b1;
        do_step();
        btn_atk = 1'b0;
        for (int k = 2; k <= 6; k++) do_step();
        total++; if (hitbox_on !== 1'b1) $display("FAIL hit_pre_active got %0b exp 1", hitbox_on); else passed++;
        @(negedge clk_pix); hit_in = 1'b1;
        @(negedge clk_pix); hit_in = 1'b0;
        exp_pos = 100;
        for (int j = 1; j <= 5; j++) begin
            do_step();
            exp_pos -= 2;
            total++; if (act_state !== HITSTUN) $display("FAIL hit_state step %0d got %0d exp %0d", j, act_state, HITSTUN); else passed++;
            total++; if (hitbox_on !== 1'b0) $display("FAIL hit_hitbox step %0d got %0b exp 0", j, hitbox_on); else passed++;
            total++; if (pos_x !== 10'(exp_pos)) $display("FAIL hit_pos step %0d got %0d exp %0d", j, pos_x, exp_pos); else passed++;
        end
        @(negedge clk_pix); hit_in = 1'b1;
        @(negedge clk_pix); hit_in = 1'b0;
        for (int j = 1; j <= 13; j++) begin
            do_step();
            if (j <= 12) exp_pos -= 2;
            total++; if (act_state !== ((j <= 12) ? HITSTUN : IDLE)) $display("FAIL rehit_state step %0d got %0d", j, act_state); else passed++;
            total++; if (busy !== (j <= 12)) $display("FAIL rehit_busy step %0d got %0b exp %0b", j, busy, (j <= 12)); else passed++;
            total++; if (pos_x !== 10'(exp_pos)) $display("FAIL rehit_pos step %0d got %0d exp %0d", j, pos_x, exp_pos); else passed++;
        end
    endtask

    task automatic test_freeze();
        @(negedge clk_pix);
        freeze  = 1'b1;
        btn_fwd = 1'b1;
        @(negedge clk_pix); hit_in = 1'b1;
        @(negedge clk_pix); hit_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            do_step();
            total++; if (act_state !== IDLE) $display("FAIL freeze_state tick %0d got %0d exp %0d", k, act_state, IDLE); else passed++;
            total++; if (pos_x !== 10'd66) $display("FAIL freeze_pos tick %0d got %0d exp 66", k, pos_x); else passed++;
        end
        btn_fwd = 1'b0;
        @(negedge clk_pix);
        freeze = 1'b0;
        do_step();
        total++; if (act_state !== IDLE) $display("FAIL freeze_hit_dropped got %0d exp %0d", act_state, IDLE); else passed++;
        total++; if (pos_x !== 10'd66) $display("FAIL freeze_after_pos got %0d exp 66", pos_x); else passed++;
        btn_fwd  = 1'b1;
        btn_back = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            do_step();
            total++; if (act_state !== IDLE) $display("FAIL both_btn_state step %0d got %0d exp %0d", k, act_state, IDLE); else passed++;
            total++; if (pos_x !== 10'd66) $display("FAIL both_btn_pos step %0d got %0d exp 66", k, pos_x); else passed++;
        end
        btn_fwd  = 1'b0;
        btn_back = 1'b0;
    endtask

    task automatic test_async_reset();
        do_step();
        btn_atk = 1'b1;
        do_step();
        btn_atk = 1'b0;
        for (int k = 2; k <= 9; k++) do_step();
        total++; if (act_state !== ATK_RECOVER) $display("FAIL rst_pre_state got %0d exp %0d", act_state, ATK_RECOVER); else passed++;
        @(negedge clk_pix);
        #2 sim_rst = 1'b1;
        #1;
        total++; if (pos_x !== 10'd100) $display("FAIL async_rst_pos got %0d exp 100", pos_x); else passed++;
        total++; if (act_state !== IDLE) $display("FAIL async_rst_state got %0d exp %0d", act_state, IDLE); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL async_rst_busy got %0b exp 0", busy); else passed++;
        @(negedge clk_pix);
        sim_rst = 1'b0;
        btn_atk = 1'b1;
        do_step();
        total++; if (act_state !== ATK_STARTUP) $display("FAIL post_rst_press got %0d exp %0d", act_state, ATK_STARTUP); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL post_rst_busy got %0b exp 1", busy); else passed++;
        btn_atk = 1'b0;
    endtask

    initial begin
        test_reset();
        test_walk();
        test_clamp();
        test_attack();
        test_hitstun();
        test_freeze();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
